// File: rtl/lfsr_pkg.sv
// Shared definitions for the 64-bit XNOR-feedback LFSR generator and its
// receive-side checker.
package lfsr_pkg;

   localparam int LFSR_W = 64;

   localparam int TAP_A = 63;
   localparam int TAP_B = 62;
   localparam int TAP_C = 60;
   localparam int TAP_D = 59;

   typedef enum logic {
      ACQUIRE = 1'b0,
      CHECK   = 1'b1
   } chk_state_t;

   // XNOR feedback: the all-ones state maps to itself, so it is a legal stream.
   function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
      return ~(s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]);
   endfunction

endpackage

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising PRBS checker: loads 64 received bits, then predicts each
// following bit and drops lock when window errors reach ERR_THRESH.
module lfsr_prbs_checker
   import lfsr_pkg::*;
#(
   parameter int ERR_THRESH = 8,
   parameter int WINDOW     = 256,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_cnt,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [31:0]      bit_count
);

   localparam int WB_W = $clog2(WINDOW);
   localparam int WE_W = $clog2(ERR_THRESH + 1);
   localparam logic [WB_W-1:0] WIN_LAST = WB_W'(WINDOW - 1);
   localparam logic [WE_W-1:0] THRESH   = WE_W'(ERR_THRESH);

   chk_state_t        state_reg;
   logic [LFSR_W-1:0] sr_reg;
   logic [6:0]        acq_reg;
   logic [WB_W-1:0]   win_bits_reg;
   logic [WE_W-1:0]   win_errs_reg;
   logic              locked_reg;
   logic              err_pulse_reg;
   logic [CNT_W-1:0]  err_count_reg;
   logic [31:0]       bit_count_reg;

   logic              pred;
   logic              mismatch;
   logic [WE_W-1:0]   win_errs_inc;
   logic [CNT_W-1:0]  err_base;
   logic [CNT_W-1:0]  err_inc;
   logic [31:0]       bit_base;
   logic [31:0]       bit_inc;

   // Clear is applied before the increment, so clear plus a hit yields 1.
   always_comb begin
      pred         = lfsr_fb(sr_reg);
      mismatch     = in_bit ^ pred;
      win_errs_inc = win_errs_reg + WE_W'(mismatch);
      err_base     = clear_cnt ? '0 : err_count_reg;
      err_inc      = (&err_base) ? err_base : err_base + CNT_W'(1);
      bit_base     = clear_cnt ? '0 : bit_count_reg;
      bit_inc      = (&bit_base) ? bit_base : bit_base + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ACQUIRE;
         sr_reg        <= '0;
         acq_reg       <= '0;
         win_bits_reg  <= '0;
         win_errs_reg  <= '0;
         locked_reg    <= 1'b0;
         err_pulse_reg <= 1'b0;
         err_count_reg <= '0;
         bit_count_reg <= '0;
      end else begin
         err_pulse_reg <= 1'b0;
         err_count_reg <= err_base;
         bit_count_reg <= bit_base;
         if (in_valid) begin
            case (state_reg)
               ACQUIRE: begin
                  sr_reg <= {sr_reg[LFSR_W-2:0], in_bit};
                  if (acq_reg == 7'd63) begin
                     state_reg    <= CHECK;
                     locked_reg   <= 1'b1;
                     acq_reg      <= '0;
                     win_bits_reg <= '0;
                     win_errs_reg <= '0;
                  end else begin
                     acq_reg <= acq_reg + 7'd1;
                  end
               end
               CHECK: begin
                  // Shift in the prediction so a single bad bit cannot corrupt sr.
                  sr_reg        <= {sr_reg[LFSR_W-2:0], pred};
                  bit_count_reg <= bit_inc;
                  if (mismatch) begin
                     err_pulse_reg <= 1'b1;
                     err_count_reg <= err_inc;
                  end
                  if (win_errs_inc == THRESH) begin
                     state_reg    <= ACQUIRE;
                     locked_reg   <= 1'b0;
                     acq_reg      <= '0;
                     win_bits_reg <= '0;
                     win_errs_reg <= '0;
                  end else if (win_bits_reg == WIN_LAST) begin
                     win_bits_reg <= '0;
                     win_errs_reg <= '0;
                  end else begin
                     win_bits_reg <= win_bits_reg + WB_W'(1);
                     win_errs_reg <= win_errs_inc;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign locked    = locked_reg;
   assign err_pulse = err_pulse_reg;
   assign err_count = err_count_reg;
   assign bit_count = bit_count_reg;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Directed bench for lfsr_prbs_checker: acquisition, error detection, window
// accounting, lock loss/relock, valid gaps, counter clear and saturation.
module tb_lfsr_prbs_checker;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear_cnt, in_valid, in_bit;
   logic        locked, err_pulse;
   logic [15:0] err_count;
   logic [31:0] bit_count;

   logic        s_clear, s_valid, s_bit;
   logic        s_locked, s_pulse;
   logic [3:0]  s_err_count;
   logic [31:0] s_bit_count;

   logic [63:0] gen;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   lfsr_prbs_checker dut (
      .clk(clk), .reset(reset), .clear_cnt(clear_cnt), .in_valid(in_valid),
      .in_bit(in_bit), .locked(locked), .err_pulse(err_pulse),
      .err_count(err_count), .bit_count(bit_count)
   );

   lfsr_prbs_checker #(.ERR_THRESH(64), .WINDOW(64), .CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .clear_cnt(s_clear), .in_valid(s_valid),
      .in_bit(s_bit), .locked(s_locked), .err_pulse(s_pulse),
      .err_count(s_err_count), .bit_count(s_bit_count)
   );

   // Reference generator: shift left, insert XNOR of taps 63,62,60,59.
   task automatic gen_next(output logic b);
      b   = ~(gen[63] ^ gen[62] ^ gen[60] ^ gen[59]);
      gen = {gen[62:0], b};
   endtask

   task automatic drive(input logic v, input logic b, input logic c);
      in_valid  = v;
      in_bit    = b;
      clear_cnt = c;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_sat(input logic v, input logic b);
      s_valid = v;
      s_bit   = b;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic acquire64(input logic [63:0] seed);
      logic b;
      gen = seed;
      for (int i = 0; i < 64; i++) begin
         gen_next(b);
         drive(1'b1, b, 1'b0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      reset = 1'b0;
      n_tests++;
      if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b want 0", locked); end
      n_tests++;
      if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %0b want 0", err_pulse); end
      n_tests++;
      if (err_count !== 16'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
      n_tests++;
      if (bit_count !== 32'd0) begin n_fail++; $display("FAIL reset_bit_count: got %0d want 0", bit_count); end
      $display("[TB] test_reset done");
   endtask

   task automatic test_acquire_check();
      logic b;
      int   pulses = 0;
      gen = 64'h0123_4567_89AB_CDEF;
      for (int i = 1; i <= 64; i++) begin
         gen_next(b);
         drive(1'b1, b, 1'b0);
         if (i == 63) begin
            n_tests++;
            if (locked !== 1'b0) begin n_fail++; $display("FAIL acq_early_lock: got %0b want 0 after 63 bits", locked); end
         end
      end
      n_tests++;
      if (locked !== 1'b1) begin n_fail++; $display("FAIL acq_lock: got %0b want 1 after 64 bits", locked); end
      for (int i = 1; i <= 1000; i++) begin
         gen_next(b);
         drive(1'b1, b, 1'b0);
         if (err_pulse) pulses++;
         if (i == 1) begin
            n_tests++;
            if (bit_count !== 32'd1) begin n_fail++; $display("FAIL first_check_count: got %0d want 1", bit_count); end
         end
      end
      n_tests++;
      if (pulses != 0) begin n_fail++; $display("FAIL clean_pulses: got %0d want 0", pulses); end
      n_tests++;
      if (err_count !== 16'd0) begin n_fail++; $display("FAIL clean_err_count: got %0d want 0", err_count); end
      n_tests++;
      if (bit_count !== 32'd1000) begin n_fail++; $display("FAIL clean_bit_count: got %0d want 1000", bit_count); end
      $display("[TB] test_acquire_check done: bit_count=%0d", bit_count);
   endtask

   task automatic test_single_errors();
      logic b;
      int   pulses = 0;
      int   misplaced = 0;
      drive(1'b0, 1'b0, 1'b1);
      n_tests++;
      if (bit_count !== 32'd0 || locked !== 1'b1) begin
         n_fail++; $display("FAIL idle_clear: bit_count %0d locked %0b want 0 and 1", bit_count, locked);
      end
      for (int i = 0; i < 400; i++) begin
         gen_next(b);
         drive(1'b1, (i == 100 || i == 300) ? ~b : b, 1'b0);
         if (err_pulse) pulses++;
         if (err_pulse !== (i == 100 || i == 300)) misplaced++;
      end
      n_tests++;
      if (pulses != 2) begin n_fail++; $display("FAIL flip_pulses: got %0d want 2", pulses); end
      n_tests++;
      if (misplaced != 0) begin n_fail++; $display("FAIL flip_pulse_timing: %0d misplaced cycles want 0", misplaced); end
      n_tests++;
      if (err_count !== 16'd2) begin n_fail++; $display("FAIL flip_err_count: got %0d want 2", err_count); end
      n_tests++;
      if (locked !== 1'b1 || bit_count !== 32'd400) begin
         n_fail++; $display("FAIL flip_lock: locked %0b bit_count %0d want 1 and 400", locked, bit_count);
      end
      $display("[TB] test_single_errors done: err_count=%0d", err_count);
   endtask

   task automatic test_window();
      logic b;
      int   pulses = 0;
      do_reset();
      acquire64(64'hFEDC_BA98_7654_3210);
      // 7 errors close window 0 (bits 249..255), 7 more open window 1.
      for (int i = 0; i < 270; i++) begin
         gen_next(b);
         drive(1'b1, (i >= 249 && i <= 262) ? ~b : b, 1'b0);
         if (err_pulse) pulses++;
      end
      n_tests++;
      if (locked !== 1'b1) begin n_fail++; $display("FAIL window_reset_lock: got %0b want 1", locked); end
      n_tests++;
      if (err_count !== 16'd14 || pulses != 14) begin
         n_fail++; $display("FAIL window_errors: err_count %0d pulses %0d want 14", err_count, pulses);
      end
      $display("[TB] test_window done: err_count=%0d", err_count);
   endtask

   task automatic test_lock_loss();
      logic b;
      int   pulses = 0;
      do_reset();
      acquire64(64'h0123_4567_89AB_CDEF);
      for (int i = 0; i < 10; i++) begin
         gen_next(b);
         drive(1'b1, b, 1'b0);
      end
      for (int k = 1; k <= 8; k++) begin
         gen_next(b);
         drive(1'b1, ~b, 1'b0);
         n_tests++;
         if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL loss_pulse_%0d: got %0b want 1", k, err_pulse); end
         if (k == 7) begin
            n_tests++;
            if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_early: got %0b want 1 after 7 errors", locked); end
         end
      end
      n_tests++;
      if (locked !== 1'b0) begin n_fail++; $display("FAIL loss_unlock: got %0b want 0 after 8 errors", locked); end
      for (int i = 1; i <= 64; i++) begin
         gen_next(b);
         drive(1'b1, b, 1'b0);
         if (i == 63) begin
            n_tests++;
            if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early: got %0b want 0", locked); end
         end
      end
      n_tests++;
      if (locked !== 1'b1) begin n_fail++; $display("FAIL relock: got %0b want 1", locked); end
      for (int i = 0; i < 50; i++) begin
         gen_next(b);
         drive(1'b1, b, 1'b0);
         if (err_pulse) pulses++;
      end
      n_tests++;
      if (pulses != 0 || err_count !== 16'd8) begin
         n_fail++; $display("FAIL relock_clean: pulses %0d err_count %0d want 0 and 8", pulses, err_count);
      end
      n_tests++;
      if (bit_count !== 32'd68) begin n_fail++; $display("FAIL relock_bit_count: got %0d want 68", bit_count); end
      $display("[TB] test_lock_loss done: bit_count=%0d", bit_count);
   endtask

   task automatic test_valid_toggle();
      logic b;
      int   bad_pulses = 0;
      do_reset();
      gen = 64'h0123_4567_89AB_CDEF;
      for (int cyc = 1; cyc <= 128; cyc++) begin
         if (cyc % 2 == 1) begin
            gen_next(b);
            drive(1'b1, b, 1'b0);
         end else begin
            drive(1'b0, 1'b1, 1'b0);
         end
         if (err_pulse) bad_pulses++;
         if (cyc == 126) begin
            n_tests++;
            if (locked !== 1'b0) begin n_fail++; $display("FAIL gap_early_lock: got %0b want 0 at cycle 126", locked); end
         end
         if (cyc == 127) begin
            n_tests++;
            if (locked !== 1'b1) begin n_fail++; $display("FAIL gap_lock: got %0b want 1 at cycle 127", locked); end
         end
      end
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (cyc % 2 == 0) begin
            gen_next(b);
            drive(1'b1, b, 1'b0);
         end else begin
            drive(1'b0, ~gen[0], 1'b0);
            if (err_pulse) bad_pulses++;
         end
      end
      n_tests++;
      if (bad_pulses != 0) begin n_fail++; $display("FAIL gap_pulses: got %0d want 0", bad_pulses); end
      n_tests++;
      if (bit_count !== 32'd10) begin n_fail++; $display("FAIL gap_bit_count: got %0d want 10", bit_count); end
      $display("[TB] test_valid_toggle done: bit_count=%0d", bit_count);
   endtask

   task automatic test_clear_collision();
      logic b;
      gen_next(b);
      drive(1'b1, ~b, 1'b0);
      n_tests++;
      if (err_count !== 16'd1) begin n_fail++; $display("FAIL pre_clear_err: got %0d want 1", err_count); end
      gen_next(b);
      drive(1'b1, ~b, 1'b1);
      n_tests++;
      if (err_count !== 16'd1 || err_pulse !== 1'b1) begin
         n_fail++; $display("FAIL clear_hit_err: err_count %0d pulse %0b want 1 and 1", err_count, err_pulse);
      end
      n_tests++;
      if (bit_count !== 32'd1) begin n_fail++; $display("FAIL clear_hit_bits: got %0d want 1", bit_count); end
      gen_next(b);
      drive(1'b1, b, 1'b1);
      n_tests++;
      if (err_count !== 16'd0 || bit_count !== 32'd1) begin
         n_fail++; $display("FAIL clear_clean: err_count %0d bit_count %0d want 0 and 1", err_count, bit_count);
      end
      $display("[TB] test_clear_collision done");
   endtask

   task automatic test_all_ones();
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 84; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         if (err_pulse) pulses++;
         if (i == 63) begin
            n_tests++;
            if (locked !== 1'b1) begin n_fail++; $display("FAIL ones_lock: got %0b want 1", locked); end
         end
      end
      n_tests++;
      if (pulses != 0 || err_count !== 16'd0 || bit_count !== 32'd20) begin
         n_fail++; $display("FAIL ones_check: pulses %0d err_count %0d bit_count %0d want 0 0 20",
                            pulses, err_count, bit_count);
      end
      $display("[TB] test_all_ones done");
   endtask

   task automatic test_saturation();
      logic b;
      int   pulses = 0;
      do_reset();
      gen = 64'h0123_4567_89AB_CDEF;
      for (int i = 0; i < 64; i++) begin
         gen_next(b);
         drive_sat(1'b1, b);
      end
      n_tests++;
      if (s_locked !== 1'b1) begin n_fail++; $display("FAIL sat_lock: got %0b want 1", s_locked); end
      for (int i = 1; i <= 20; i++) begin
         gen_next(b);
         drive_sat(1'b1, ~b);
         if (s_pulse) pulses++;
         if (i == 15) begin
            n_tests++;
            if (s_err_count !== 4'hF) begin n_fail++; $display("FAIL sat_reach: got %0h want f", s_err_count); end
         end
      end
      n_tests++;
      if (s_err_count !== 4'hF || pulses != 20) begin
         n_fail++; $display("FAIL sat_hold: err_count %0h pulses %0d want f and 20", s_err_count, pulses);
      end
      n_tests++;
      if (s_locked !== 1'b1 || s_bit_count !== 32'd20) begin
         n_fail++; $display("FAIL sat_state: locked %0b bit_count %0d want 1 and 20", s_locked, s_bit_count);
      end
      $display("[TB] test_saturation done: err_count=%0h", s_err_count);
   endtask

   task automatic test_reset_mid();
      logic b;
      int   pulses = 0;
      do_reset();
      acquire64(64'h0F0F_1234_5678_9ABC);
      for (int i = 0; i < 30; i++) begin
         gen_next(b);
         drive(1'b1, (i == 10 || i == 29) ? ~b : b, 1'b0);
      end
      reset = 1'b1;
      gen_next(b);
      drive(1'b1, ~b, 1'b1);
      reset = 1'b0;
      n_tests++;
      if (locked !== 1'b0 || err_pulse !== 1'b0) begin
         n_fail++; $display("FAIL midreset_state: locked %0b pulse %0b want 0 and 0", locked, err_pulse);
      end
      n_tests++;
      if (err_count !== 16'd0 || bit_count !== 32'd0) begin
         n_fail++; $display("FAIL midreset_counts: err_count %0d bit_count %0d want 0", err_count, bit_count);
      end
      for (int i = 0; i < 64; i++) begin
         gen_next(b);
         drive(1'b1, b, 1'b0);
      end
      n_tests++;
      if (locked !== 1'b1) begin n_fail++; $display("FAIL midreset_relock: got %0b want 1", locked); end
      for (int i = 0; i < 10; i++) begin
         gen_next(b);
         drive(1'b1, b, 1'b0);
         if (err_pulse) pulses++;
      end
      n_tests++;
      if (pulses != 0 || bit_count !== 32'd10) begin
         n_fail++; $display("FAIL midreset_clean: pulses %0d bit_count %0d want 0 and 10", pulses, bit_count);
      end
      $display("[TB] test_reset_mid done");
   endtask

   initial begin
      reset     = 1'b1;
      clear_cnt = 1'b0;
      in_valid  = 1'b0;
      in_bit    = 1'b0;
      s_clear   = 1'b0;
      s_valid   = 1'b0;
      s_bit     = 1'b0;
      test_reset();
      test_acquire_check();
      test_single_errors();
      test_window();
      test_lock_loss();
      test_valid_toggle();
      test_clear_collision();
      test_all_ones();
      test_saturation();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lfsr_prbs_checker.md
# lfsr_prbs_checker

Serial receive-side checker for the 64-bit XNOR-feedback LFSR stream generated elsewhere in the design. It self-synchronises by loading 64 received bits into a local shadow register. It then predicts each following bit and flags any mismatch. Lock is declared lost when errors within a sliding block window reach a threshold, and the block then re-acquires. It sits at the far end of the serial link, beside the generator on loopback or on the peer board, and feeds status LEDs and counters.

## Interface
- ERR_THRESH, default 8: errors within one window that force loss of lock (1..WINDOW).
- WINDOW, default 256: number of checked bits per error window (power of two, ≥ 64).
- CNT_W, default 16: width of `err_count`.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- clear_cnt  in  1  synchronous clear of `err_count` and `bit_count`; does not affect lock.
- in_valid  in  1  qualifies `in_bit`; one bit consumed per cycle with in_valid=1. There is no backpressure.
- in_bit  in  1  received stream bit.
- locked  out  1  high while in CHECK state.
- err_pulse  out  1  one-cycle pulse per mismatched bit.
- err_count  out  CNT_W  saturating total mismatch count.
- bit_count  out  32  saturating count of bits checked while locked.

## Operation
- Stream definition: the generator shifts left each step and inserts fb = ~(s[63]^s[62]^s[60]^s[59]) at s[0]. The serial stream is the sequence of inserted fb bits.
- Shadow register `sr[63:0]`, acquire counter `acq[6:0]`, window bit counter, window error counter.
- State ACQUIRE (reset state):
  - Each valid bit: sr <= {sr[62:0], in_bit}; acq++.
  - When the 64th bit is accepted (acq==63), go to CHECK. Window counters are cleared.
- State CHECK, each valid bit:
  - pred = ~(sr[63]^sr[62]^sr[60]^sr[59]).
  - sr <= {sr[62:0], pred}. The predicted bit is shifted in, not the received one, so single errors do not propagate.
  - Mismatch (in_bit != pred): err_pulse, err_count++ (saturate at all-ones), window errors++.
  - bit_count++ (saturate).
  - If the updated window error count reaches ERR_THRESH, go to ACQUIRE; acq=0 and sr is reloaded from the stream.
  - Otherwise, on the WINDOW-th checked bit, both window counters reset to 0.
- Ordering on the bit that closes a window: the error is counted first, the threshold is compared, then the window resets. A threshold hit takes precedence over the window reset.
- clear_cnt and a mismatch in the same cycle: the counter becomes 1. The clear applies first, then the increment. The same rule applies to bit_count.
- in_valid=0: no state change and no pulse.
- All-ones stream (LFSR lockup state) is a legal stream: it acquires and checks error-free.

## Timing
- All outputs are registered.
- Reset values: locked=0, err_pulse=0, err_count=0, bit_count=0, sr=0, acq=0, state ACQUIRE.
- locked rises the cycle after the 64th acquire bit is accepted.
- err_pulse, err_count and bit_count update the cycle after the offending or checked bit is accepted.
- locked falls the cycle after the bit that reaches ERR_THRESH. That bit's err_pulse is still issued.
- Reset mid-operation: returns to ACQUIRE with all counters 0 on the next edge; clear_cnt is ignored.
- Throughput: 1 bit/cycle sustained.

## Structure
- Shared package `lfsr_pkg`, also used by the generator:
  - localparam LFSR_W=64.
  - Tap constants 63, 62, 60, 59.
  - function `lfsr_fb(logic [63:0])` returning the XNOR feedback bit.
  - typedef enum `chk_state_t` {ACQUIRE, CHECK}.
- No sub-module. Single module: state register, shift register, three counters.

## Test plan
- Seed 64'h0123_4567_89AB_CDEF; feed 64+1000 generator bits continuously -> locked=1 at cycle 65; err_count=0; bit_count=1000.
- After lock, flip stream bit 100 and bit 300 -> exactly two err_pulse, err_count=2, locked stays 1, sr unaffected (later bits clean).
- After lock, feed 8 inverted bits in one window (ERR_THRESH=8) -> 8 pulses, locked=0 the cycle after the 8th; clean bits then relock after 64 more bits.
- in_valid toggling 1,0,1,0 during acquire -> lock after the 64th valid bit only (128 cycles); no pulses while in_valid=0.
- Mismatch coinciding with clear_cnt -> err_count=1. Force err_count to 16'hFFFF plus further errors -> it holds 16'hFFFF.
- Assert reset for 1 cycle while locked mid-stream -> locked=0, counters 0 next cycle; reacquire after 64 bits.
